// File: rtl/bp_wb_scheduler.sv
// bp_wb_scheduler
//   Drives a whole layer write-back from the BP buffer bank to DDR. Each job
//   covers two consecutive MAC groups of one line region and is handed to the
//   BP write controller with a single wc_conf pulse. Tiles form the outer loop
//   and MAC-group pairs the inner loop. Between jobs the scheduler waits for
//   the write controller to report idle again.
//
// Ports
//   clk, rst_n        : clock, synchronous active-low reset
//   start             : one-cycle layer start, honoured only while idle
//   cfg_*             : layer configuration, sampled on an accepted start
//   wc_idle           : write controller idle level
//   wc_conf           : one-cycle job launch
//   wc_ddr_st_addr    : job DDR byte address
//   wc_data_ddr_byte  : job length in bytes
//   wc_bp_st_addr     : job BP start address
//   wc_bp_st_num      : first MAC group of the job
//   wc_line_width     : BP words per line for the current layer
//   busy, done        : layer in progress / one-cycle completion pulse
//   jobs_issued       : conf pulses issued in the current layer
module bp_wb_scheduler #(
  parameter int DDR_ADDR_LEN = 32,
  parameter int ADDR_LEN     = 16,
  parameter int SINGLE_LEN   = 24,
  parameter int X_MAC        = 4,
  parameter int GUARD_CYC    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [DDR_ADDR_LEN-1:0] cfg_ddr_base,
  input  logic [SINGLE_LEN-1:0]   cfg_job_bytes,
  input  logic [ADDR_LEN-1:0]     cfg_bp_base,
  input  logic [SINGLE_LEN-1:0]   cfg_line_width,
  input  logic [SINGLE_LEN-1:0]   cfg_num_tiles,
  input  logic                    wc_idle,
  output logic                    wc_conf,
  output logic [DDR_ADDR_LEN-1:0] wc_ddr_st_addr,
  output logic [SINGLE_LEN-1:0]   wc_data_ddr_byte,
  output logic [ADDR_LEN-1:0]     wc_bp_st_addr,
  output logic [1:0]              wc_bp_st_num,
  output logic [SINGLE_LEN-1:0]   wc_line_width,
  output logic                    busy,
  output logic                    done,
  output logic [SINGLE_LEN-1:0]   jobs_issued
);

  localparam int PAIRS = X_MAC / 2;
  localparam int PW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int GW    = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
  localparam logic [PW-1:0] LAST_PAIR  = PW'(PAIRS - 1);
  localparam logic [GW-1:0] LAST_GUARD = GW'(GUARD_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_IDLE,
    S_ISSUE,
    S_GUARD,
    S_NEXT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [DDR_ADDR_LEN-1:0] ddr_acc_reg;
  logic [ADDR_LEN-1:0]     bp_acc_reg;
  logic [SINGLE_LEN-1:0]   job_bytes_reg;
  logic [SINGLE_LEN-1:0]   line_width_reg;
  logic [SINGLE_LEN-1:0]   num_tiles_reg;
  logic [SINGLE_LEN-1:0]   tile_cnt_reg;
  logic [PW-1:0]           pair_cnt_reg;
  logic [GW-1:0]           guard_cnt_reg;
  logic [SINGLE_LEN-1:0]   jobs_reg;
  logic [DDR_ADDR_LEN-1:0] ddr_out_reg;
  logic [ADDR_LEN-1:0]     bp_out_reg;
  logic [1:0]              num_out_reg;
  logic                    last_job;

  // The job just issued closes the layer when it was the last pair of the
  // last tile (counters still hold the values of that job in S_NEXT).
  assign last_job = (pair_cnt_reg == LAST_PAIR) &&
                    (tile_cnt_reg == num_tiles_reg - SINGLE_LEN'(1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:      if (start) state_next = S_WAIT_IDLE;
      // A zero-tile layer spends its single busy cycle here and skips
      // straight to completion without touching the write controller.
      S_WAIT_IDLE: begin
        if (num_tiles_reg == '0) state_next = S_DONE;
        else if (wc_idle)        state_next = S_ISSUE;
      end
      S_ISSUE:     state_next = S_GUARD;
      // wc_idle is deliberately ignored here: right after conf it may still
      // show the idle level from before the job was accepted.
      S_GUARD:     if (guard_cnt_reg == LAST_GUARD) state_next = S_NEXT;
      S_NEXT:      state_next = last_job ? S_DRAIN : S_WAIT_IDLE;
      S_DRAIN:     if (wc_idle) state_next = S_DONE;
      S_DONE:      state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      ddr_acc_reg    <= '0;
      bp_acc_reg     <= '0;
      job_bytes_reg  <= '0;
      line_width_reg <= '0;
      num_tiles_reg  <= '0;
      tile_cnt_reg   <= '0;
      pair_cnt_reg   <= '0;
      guard_cnt_reg  <= '0;
      jobs_reg       <= '0;
      ddr_out_reg    <= '0;
      bp_out_reg     <= '0;
      num_out_reg    <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            ddr_acc_reg    <= cfg_ddr_base;
            bp_acc_reg     <= cfg_bp_base;
            job_bytes_reg  <= cfg_job_bytes;
            line_width_reg <= cfg_line_width;
            num_tiles_reg  <= cfg_num_tiles;
            tile_cnt_reg   <= '0;
            pair_cnt_reg   <= '0;
            jobs_reg       <= '0;
          end
        end
        S_WAIT_IDLE: begin
          // Job outputs are loaded on entry to S_ISSUE and then held until
          // the following job, so they stay stable for the write controller.
          if (state_next == S_ISSUE) begin
            ddr_out_reg <= ddr_acc_reg;
            bp_out_reg  <= bp_acc_reg;
            num_out_reg <= 2'(pair_cnt_reg) << 1;
          end
        end
        S_ISSUE: begin
          jobs_reg      <= jobs_reg + SINGLE_LEN'(1);
          guard_cnt_reg <= '0;
        end
        S_GUARD: guard_cnt_reg <= guard_cnt_reg + GW'(1);
        S_NEXT: begin
          ddr_acc_reg <= ddr_acc_reg + DDR_ADDR_LEN'(job_bytes_reg);
          if (pair_cnt_reg == LAST_PAIR) begin
            pair_cnt_reg <= '0;
            tile_cnt_reg <= tile_cnt_reg + SINGLE_LEN'(1);
            bp_acc_reg   <= bp_acc_reg + ADDR_LEN'(line_width_reg);
          end else begin
            pair_cnt_reg <= pair_cnt_reg + PW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign wc_conf          = (state_reg == S_ISSUE);
  assign done             = (state_reg == S_DONE);
  assign busy             = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign wc_ddr_st_addr   = ddr_out_reg;
  assign wc_bp_st_addr    = bp_out_reg;
  assign wc_bp_st_num     = num_out_reg;
  assign wc_data_ddr_byte = job_bytes_reg;
  assign wc_line_width    = line_width_reg;
  assign jobs_issued      = jobs_reg;

endmodule

// File: tb/tb_bp_wb_scheduler.sv
// Testbench for bp_wb_scheduler: table-driven layers, hand-written timing and
// corner sequences, then randomized layers checked against a job-list model.
module tb_bp_wb_scheduler;

  localparam int PAIRS = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] cfg_ddr_base = '0;
  logic [23:0] cfg_job_bytes = '0;
  logic [15:0] cfg_bp_base = '0;
  logic [23:0] cfg_line_width = '0;
  logic [23:0] cfg_num_tiles = '0;
  logic        wc_idle = 1'b1;
  logic        wc_conf;
  logic [31:0] wc_ddr_st_addr;
  logic [23:0] wc_data_ddr_byte;
  logic [15:0] wc_bp_st_addr;
  logic [1:0]  wc_bp_st_num;
  logic [23:0] wc_line_width;
  logic        busy;
  logic        done;
  logic [23:0] jobs_issued;

  bp_wb_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_ddr_base(cfg_ddr_base), .cfg_job_bytes(cfg_job_bytes),
    .cfg_bp_base(cfg_bp_base), .cfg_line_width(cfg_line_width),
    .cfg_num_tiles(cfg_num_tiles), .wc_idle(wc_idle),
    .wc_conf(wc_conf), .wc_ddr_st_addr(wc_ddr_st_addr),
    .wc_data_ddr_byte(wc_data_ddr_byte), .wc_bp_st_addr(wc_bp_st_addr),
    .wc_bp_st_num(wc_bp_st_num), .wc_line_width(wc_line_width),
    .busy(busy), .done(done), .jobs_issued(jobs_issued)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] ddr;
    logic [15:0] bp;
    logic [1:0]  num;
    logic [23:0] bytes;
    logic [23:0] lw;
    int          cyc;
  } conf_t;

  conf_t conf_q[$];
  int    done_cnt = 0;
  int    done_cyc = 0;
  int    busy_cnt = 0;
  int    start_cyc = 0;
  int    idle_delay = 0;
  int    idle_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  // Write controller: goes busy for idle_delay cycles after every conf.
  always @(negedge clk) begin
    if (wc_conf) idle_cnt = idle_delay;
    else if (idle_cnt > 0) idle_cnt = idle_cnt - 1;
    wc_idle = (idle_cnt == 0);
  end

  // Monitor: records launches, done pulses and busy cycles; checks that job
  // outputs hold still between launches within a layer.
  logic [31:0] last_ddr;
  logic [15:0] last_bp;
  logic        have_last = 1'b0;
  always @(negedge clk) begin
    if (!busy) have_last = 1'b0;
    if (wc_conf) begin
      conf_q.push_back('{ddr: wc_ddr_st_addr, bp: wc_bp_st_addr, num: wc_bp_st_num,
                         bytes: wc_data_ddr_byte, lw: wc_line_width, cyc: cyc});
      last_ddr  = wc_ddr_st_addr;
      last_bp   = wc_bp_st_addr;
      have_last = 1'b1;
    end else if (busy && have_last) begin
      checks++;
      if (wc_ddr_st_addr !== last_ddr || wc_bp_st_addr !== last_bp) begin
        errors++;
        $display("FAIL hold_between_confs actual=%h/%h expected=%h/%h",
                 wc_ddr_st_addr, wc_bp_st_addr, last_ddr, last_bp);
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) busy_cnt++;
  end

  // Reference model: job i belongs to tile i/PAIRS and pair i%PAIRS.
  function automatic logic [31:0] m_ddr(input logic [31:0] db, input logic [23:0] jb, input int i);
    return db + 32'(i) * {8'd0, jb};
  endfunction
  function automatic logic [15:0] m_bp(input logic [15:0] bb, input logic [23:0] lw, input int i);
    logic [31:0] full;
    full = {16'd0, bb} + 32'(i / PAIRS) * {8'd0, lw};
    return full[15:0];
  endfunction
  function automatic logic [1:0] m_num(input int i);
    return 2'(2 * (i % PAIRS));
  endfunction

  task automatic pulse_start(input logic [31:0] db, input logic [23:0] jb, input logic [15:0] bb,
                             input logic [23:0] lw, input logic [23:0] nt);
    @(negedge clk);
    cfg_ddr_base = db; cfg_job_bytes = jb; cfg_bp_base = bb;
    cfg_line_width = lw; cfg_num_tiles = nt;
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    // Scramble the config inputs: the layer must run from the latched copy.
    cfg_ddr_base = ~db; cfg_job_bytes = ~jb; cfg_bp_base = ~bb;
    cfg_line_width = ~lw; cfg_num_tiles = nt + 24'd3;
  endtask

  task automatic wait_done(input int base, input int limit, input string tag);
    for (int k = 0; k < limit && done_cnt <= base; k++) @(negedge clk);
    chk({tag, "_done_seen"}, 64'(done_cnt > base), 64'(1));
  endtask

  task automatic wait_confs(input int n, input int limit, input string tag);
    for (int k = 0; k < limit && conf_q.size() < n; k++) @(negedge clk);
    chk({tag, "_conf_seen"}, 64'(conf_q.size() >= n), 64'(1));
  endtask

  task automatic check_layer(input logic [31:0] db, input logic [23:0] jb, input logic [15:0] bb,
                             input logic [23:0] lw, input logic [23:0] nt, input int dbase,
                             input string tag);
    int exp_n;
    exp_n = int'(nt) * PAIRS;
    chk({tag, "_njobs"}, 64'(conf_q.size()), 64'(exp_n));
    chk({tag, "_ndone"}, 64'(done_cnt - dbase), 64'(1));
    chk({tag, "_jobs_issued"}, 64'(jobs_issued), 64'(exp_n));
    for (int i = 0; i < conf_q.size() && i < exp_n; i++) begin
      chk($sformatf("%s_j%0d_ddr", tag, i), 64'(conf_q[i].ddr), 64'(m_ddr(db, jb, i)));
      chk($sformatf("%s_j%0d_bp", tag, i), 64'(conf_q[i].bp), 64'(m_bp(bb, lw, i)));
      chk($sformatf("%s_j%0d_num", tag, i), 64'(conf_q[i].num), 64'(m_num(i)));
      chk($sformatf("%s_j%0d_bytes", tag, i), 64'(conf_q[i].bytes), 64'(jb));
      chk($sformatf("%s_j%0d_lw", tag, i), 64'(conf_q[i].lw), 64'(lw));
    end
  endtask

  task automatic run_layer(input logic [31:0] db, input logic [23:0] jb, input logic [15:0] bb,
                           input logic [23:0] lw, input logic [23:0] nt, input int dly,
                           input string tag);
    int dbase;
    idle_delay = dly;
    conf_q.delete();
    dbase = done_cnt;
    busy_cnt = 0;
    pulse_start(db, jb, bb, lw, nt);
    wait_done(dbase, 3000, tag);
    repeat (3) @(negedge clk);
    check_layer(db, jb, bb, lw, nt, dbase, tag);
  endtask

  typedef struct {
    logic [31:0] db;
    logic [23:0] jb;
    logic [15:0] bb;
    logic [23:0] lw;
    logic [23:0] nt;
    int          dly;
    int          exp_jobs;
    logic [31:0] exp_last_ddr;
    logic [15:0] exp_last_bp;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int dbase;
    logic [31:0] rdb;
    logic [23:0] rjb, rlw, rnt;
    logic [15:0] rbb;

    vecs[0] = '{32'h0000_1000, 24'h200, 16'h0010, 24'd8,    24'd2, 20, 4, 32'h0000_1600, 16'h0018};
    vecs[1] = '{32'h0000_0000, 24'h080, 16'h0000, 24'd4,    24'd0, 5,  0, 32'h0000_0000, 16'h0000};
    vecs[2] = '{32'hFFFF_FE00, 24'h200, 16'h0020, 24'd4,    24'd1, 3,  2, 32'h0000_0000, 16'h0020};
    vecs[3] = '{32'h0000_0100, 24'h040, 16'hFFF0, 24'h10,   24'd3, 0,  6, 32'h0000_0240, 16'h0010};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_conf", 64'(wc_conf), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_jobs", 64'(jobs_issued), 64'(0));
    chk("rst_addr", 64'({wc_ddr_st_addr, wc_bp_st_addr, wc_bp_st_num}), 64'(0));
    chk("rst_len", 64'({wc_data_ddr_byte, wc_line_width}), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven layers
    for (int v = 0; v < 4; v++) begin
      run_layer(vecs[v].db, vecs[v].jb, vecs[v].bb, vecs[v].lw, vecs[v].nt, vecs[v].dly,
                $sformatf("vec%0d", v));
      chk($sformatf("vec%0d_tbl_njobs", v), 64'(conf_q.size()), 64'(vecs[v].exp_jobs));
      if (vecs[v].exp_jobs > 0 && conf_q.size() == vecs[v].exp_jobs) begin
        chk($sformatf("vec%0d_tbl_last_ddr", v), 64'(conf_q[vecs[v].exp_jobs-1].ddr),
            64'(vecs[v].exp_last_ddr));
        chk($sformatf("vec%0d_tbl_last_bp", v), 64'(conf_q[vecs[v].exp_jobs-1].bp),
            64'(vecs[v].exp_last_bp));
      end
    end

    // Zero tiles: done two cycles after start, busy for one cycle only
    run_layer(32'h40, 24'h10, 16'h4, 24'd2, 24'd0, 0, "zero");
    chk("zero_done_latency", 64'(done_cyc - start_cyc), 64'(2));
    chk("zero_busy_cycles", 64'(busy_cnt), 64'(1));

    // Idle held high: launch latency, conf spacing and done spacing
    run_layer(32'h8000, 24'h100, 16'h30, 24'd6, 24'd1, 0, "fast");
    if (conf_q.size() == 2) begin
      chk("fast_first_conf_latency", 64'(conf_q[0].cyc - start_cyc), 64'(2));
      chk("fast_conf_gap", 64'(conf_q[1].cyc - conf_q[0].cyc), 64'(5));
      chk("fast_done_gap", 64'(done_cyc - conf_q[1].cyc), 64'(5));
    end

    // Start while busy with a different config is ignored
    idle_delay = 20;
    conf_q.delete();
    dbase = done_cnt;
    pulse_start(32'h2000, 24'h300, 16'h100, 24'd12, 24'd2);
    wait_confs(1, 200, "midstart");
    pulse_start(32'h9999_0000, 24'h7, 16'h7777, 24'd1, 24'd9);
    wait_done(dbase, 3000, "midstart");
    repeat (3) @(negedge clk);
    check_layer(32'h2000, 24'h300, 16'h100, 24'd12, 24'd2, dbase, "midstart");

    // Reset between conf 2 and 3 aborts the layer silently
    idle_delay = 20;
    conf_q.delete();
    pulse_start(32'h3000, 24'h40, 16'h8, 24'd4, 24'd2);
    wait_confs(2, 300, "abort");
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    dbase = done_cnt;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_conf_done", 64'({wc_conf, done}), 64'(0));
    chk("abort_jobs", 64'(jobs_issued), 64'(0));
    chk("abort_addr", 64'({wc_ddr_st_addr, wc_bp_st_addr, wc_bp_st_num}), 64'(0));
    chk("abort_len", 64'({wc_data_ddr_byte, wc_line_width}), 64'(0));
    repeat (80) @(negedge clk);
    chk("abort_no_more_conf", 64'(conf_q.size()), 64'(2));
    chk("abort_no_done", 64'(done_cnt - dbase), 64'(0));

    // Randomized layers
    for (int r = 0; r < 20; r++) begin
      rdb = $urandom;
      rjb = 24'($urandom);
      rbb = 16'($urandom);
      rlw = 24'($urandom_range(0, 2000));
      rnt = 24'($urandom_range(0, 4));
      run_layer(rdb, rjb, rbb, rlw, rnt, int'($urandom_range(0, 8)), $sformatf("rnd%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
